// File: rtl/snitch_shared_muldiv_arbiter.sv
// Shares one in-order mul/div unit among NrCores Snitch cores: round-robin request
// arbitration with stall lock, plus an ordering FIFO that routes responses back.
module snitch_shared_muldiv_arbiter #(
  parameter int unsigned NrCores        = 4,
  parameter int unsigned ReqWidth       = 69,
  parameter int unsigned RspWidth       = 32,
  parameter int unsigned IdWidth        = 5,
  parameter int unsigned MaxOutstanding = 4
) (
  input  logic                                 clk_i,
  input  logic                                 rst_i,
  input  logic [NrCores-1:0]                   core_q_valid_i,
  output logic [NrCores-1:0]                   core_q_ready_o,
  input  logic [NrCores*ReqWidth-1:0]          core_q_data_i,
  input  logic [NrCores*IdWidth-1:0]           core_q_id_i,
  output logic [NrCores-1:0]                   core_p_valid_o,
  input  logic [NrCores-1:0]                   core_p_ready_i,
  output logic [RspWidth-1:0]                  core_p_data_o,
  output logic [IdWidth-1:0]                   core_p_id_o,
  output logic                                 muldiv_q_valid_o,
  input  logic                                 muldiv_q_ready_i,
  output logic [ReqWidth-1:0]                  muldiv_q_data_o,
  output logic [IdWidth-1:0]                   muldiv_q_id_o,
  input  logic                                 muldiv_p_valid_i,
  output logic                                 muldiv_p_ready_o,
  input  logic [RspWidth-1:0]                  muldiv_p_data_i,
  input  logic [IdWidth-1:0]                   muldiv_p_id_i,
  output logic [$clog2(MaxOutstanding):0]      outstanding_o
);

  localparam int unsigned IdxW = $clog2(NrCores);
  localparam int unsigned PtrW = $clog2(MaxOutstanding);
  localparam int unsigned CntW = PtrW + 1;

  logic [IdxW-1:0] prio_q, prio_d;
  logic            lock_q, lock_d;
  logic [IdxW-1:0] lock_idx_q, lock_idx_d;
  logic [IdxW-1:0] fifo_q [MaxOutstanding];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic            any_req, full, empty, push, pop;
  logic [IdxW-1:0] rr_winner, winner, head;

  assign any_req = |core_q_valid_i;
  assign full    = (cnt_q == CntW'(MaxOutstanding));
  assign empty   = (cnt_q == '0);
  assign head    = fifo_q[rd_ptr_q];
  assign winner  = lock_q ? lock_idx_q : rr_winner;
  assign push    = muldiv_q_valid_o && muldiv_q_ready_i;
  assign pop     = muldiv_p_valid_i && muldiv_p_ready_o;

  // Round-robin search starting at the priority pointer, wrapping at NrCores
  always_comb begin
    int unsigned idx;
    logic        found;
    rr_winner = prio_q;
    found     = 1'b0;
    for (int unsigned k = 0; k < NrCores; k++) begin
      idx = 32'(prio_q) + k;
      if (idx >= NrCores) idx = idx - NrCores;
      if (!found && core_q_valid_i[IdxW'(idx)]) begin
        found     = 1'b1;
        rr_winner = IdxW'(idx);
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q     <= '0;
      lock_q     <= 1'b0;
      lock_idx_q <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      for (int unsigned i = 0; i < MaxOutstanding; i++) fifo_q[i] <= '0;
    end else begin
      prio_q     <= prio_d;
      lock_q     <= lock_d;
      lock_idx_q <= lock_idx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      if (push) fifo_q[wr_ptr_q] <= winner;
    end
  end

  // Next-state: pointer advances past the winner on handshake, lock holds a stalled grant
  always_comb begin
    prio_d     = prio_q;
    lock_d     = muldiv_q_valid_o && !muldiv_q_ready_i;
    lock_idx_d = winner;
    wr_ptr_d   = wr_ptr_q + PtrW'(push);
    rd_ptr_d   = rd_ptr_q + PtrW'(pop);
    cnt_d      = cnt_q + CntW'(push) - CntW'(pop);
    if (push) prio_d = (winner == IdxW'(NrCores - 1)) ? '0 : winner + 1'b1;
  end

  always_comb begin
    int unsigned q_base;
    q_base           = 32'(winner) * ReqWidth;
    muldiv_q_valid_o = any_req && !full;
    muldiv_q_data_o  = '0;
    muldiv_q_id_o    = '0;
    core_q_ready_o   = '0;
    if (muldiv_q_valid_o) begin
      muldiv_q_data_o = core_q_data_i[q_base +: ReqWidth];
      muldiv_q_id_o   = core_q_id_i[32'(winner) * IdWidth +: IdWidth];
      core_q_ready_o[winner] = muldiv_q_ready_i;
    end
    core_p_valid_o = '0;
    for (int unsigned i = 0; i < NrCores; i++) begin
      core_p_valid_o[i] = muldiv_p_valid_i && !empty && (head == IdxW'(i));
    end
    muldiv_p_ready_o = !empty && core_p_ready_i[head];
    core_p_data_o    = muldiv_p_data_i;
    core_p_id_o      = muldiv_p_id_i;
    outstanding_o    = cnt_q;
  end

  a_p_onehot: assert property (@(posedge clk_i) disable iff (rst_i) $onehot0(core_p_valid_o));
  a_no_push_full: assert property (@(posedge clk_i) disable iff (rst_i) !(push && full));
  a_q_stable: assert property (@(posedge clk_i) disable iff (rst_i)
    (muldiv_q_valid_o && !muldiv_q_ready_i) |=>
      (muldiv_q_valid_o && $stable(muldiv_q_data_o) && $stable(muldiv_q_id_o)));
  a_rsp_when_empty: assert property (@(posedge clk_i) disable iff (rst_i) muldiv_p_valid_i |-> !empty);

endmodule

// File: tb/tb_snitch_shared_muldiv_arbiter.sv
// Bench for snitch_shared_muldiv_arbiter: directed scenarios with literal expectations
// followed by randomized traffic, all compared every cycle against a queue-based model.
module tb_snitch_shared_muldiv_arbiter;
  localparam int unsigned N  = 4;
  localparam int unsigned RW = 69;
  localparam int unsigned PW = 32;
  localparam int unsigned IW = 5;
  localparam int unsigned MO = 4;
  localparam int unsigned CW = $clog2(MO) + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          req_v  [N];
  logic [RW-1:0] req_d  [N];
  logic [IW-1:0] req_id [N];

  logic [N-1:0]    core_q_valid, core_q_ready, core_p_valid, core_p_ready;
  logic [N*RW-1:0] core_q_data;
  logic [N*IW-1:0] core_q_id;
  logic [PW-1:0]   core_p_data, mp_data;
  logic [IW-1:0]   core_p_id, mq_id, mp_id;
  logic            mq_valid, mq_ready, mp_valid, mp_ready;
  logic [RW-1:0]   mq_data;
  logic [CW-1:0]   outstanding;

  always_comb begin
    for (int i = 0; i < N; i++) begin
      core_q_valid[i]            = req_v[i];
      core_q_data[i*RW +: RW]    = req_d[i];
      core_q_id[i*IW +: IW]      = req_id[i];
    end
  end

  snitch_shared_muldiv_arbiter #(
    .NrCores(N), .ReqWidth(RW), .RspWidth(PW), .IdWidth(IW), .MaxOutstanding(MO)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .core_q_valid_i(core_q_valid), .core_q_ready_o(core_q_ready),
    .core_q_data_i(core_q_data), .core_q_id_i(core_q_id),
    .core_p_valid_o(core_p_valid), .core_p_ready_i(core_p_ready),
    .core_p_data_o(core_p_data), .core_p_id_o(core_p_id),
    .muldiv_q_valid_o(mq_valid), .muldiv_q_ready_i(mq_ready),
    .muldiv_q_data_o(mq_data), .muldiv_q_id_o(mq_id),
    .muldiv_p_valid_i(mp_valid), .muldiv_p_ready_o(mp_ready),
    .muldiv_p_data_i(mp_data), .muldiv_p_id_i(mp_id),
    .outstanding_o(outstanding)
  );

  // Model: issue order of cores still awaiting a response, rr pointer, held grant
  int order_q[$];
  int ptr;
  int held;
  int last_w;
  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int model_winner();
    if (held >= 0) return held;
    for (int k = 0; k < N; k++) begin
      if (req_v[(ptr + k) % N]) return (ptr + k) % N;
    end
    return -1;
  endfunction

  task automatic model_clear();
    order_q.delete();
    ptr  = 0;
    held = -1;
  endtask

  // Compare all outputs against the model, then advance one clock
  task automatic tick();
    int          w, h;
    logic        qv, pr;
    logic [N-1:0] qr, pvv;
    bit          qhs, phs;
    #1;
    w  = model_winner();
    qv = (w >= 0) && (order_q.size() < MO);
    qr = '0;
    if (qv && mq_ready) qr[w] = 1'b1;
    h   = (order_q.size() > 0) ? order_q[0] : -1;
    pvv = '0;
    pr  = 1'b0;
    if (h >= 0) begin
      pvv[h] = mp_valid;
      pr     = core_p_ready[h];
    end
    chk("q_valid", 128'(mq_valid), 128'(qv));
    chk("q_ready", 128'(core_q_ready), 128'(qr));
    if (qv) begin
      chk("q_data", 128'(mq_data), 128'(req_d[w]));
      chk("q_id", 128'(mq_id), 128'(req_id[w]));
    end
    chk("p_valid", 128'(core_p_valid), 128'(pvv));
    chk("p_ready", 128'(mp_ready), 128'(pr));
    if (|pvv) begin
      chk("p_data", 128'(core_p_data), 128'(mp_data));
      chk("p_id", 128'(core_p_id), 128'(mp_id));
    end
    chk("outstanding", 128'(outstanding), 128'(order_q.size()));
    qhs = qv && mq_ready;
    phs = mp_valid && pr;
    @(posedge clk);
    last_w = -1;
    if (rst) begin
      model_clear();
    end else begin
      if (phs) void'(order_q.pop_front());
      if (qhs) begin
        order_q.push_back(w);
        ptr    = (w + 1) % N;
        held   = -1;
        last_w = w;
      end else begin
        held = qv ? w : -1;
      end
    end
    @(negedge clk);
  endtask

  task automatic set_idle();
    for (int i = 0; i < N; i++) req_v[i] = 1'b0;
    mq_ready     = 1'b0;
    mp_valid     = 1'b0;
    mp_data      = '0;
    mp_id        = '0;
    core_p_ready = '1;
  endtask

  task automatic new_req(input int c);
    req_v[c]  = 1'b1;
    req_d[c]  = RW'({$urandom(), $urandom(), $urandom()});
    req_id[c] = IW'($urandom());
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    model_clear();
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic drain();
    mq_ready     = 1'b0;
    core_p_ready = '1;
    for (int i = 0; i < 40 && order_q.size() > 0; i++) begin
      mp_valid = 1'b1;
      mp_data  = $urandom();
      tick();
    end
    mp_valid = 1'b0;
    chk("drain_empty", 128'(order_q.size()), 128'(0));
  endtask

  logic [RW-1:0] p1_payload;

  initial begin
    for (int i = 0; i < N; i++) begin
      req_v[i] = 1'b0; req_d[i] = '0; req_id[i] = '0;
    end
    set_idle();
    rst = 1'b1;
    model_clear();
    @(negedge clk);

    // Reset state
    #1;
    chk("rst_outstanding", 128'(outstanding), 128'(0));
    chk("rst_q_valid", 128'(mq_valid), 128'(0));
    chk("rst_q_ready", 128'(core_q_ready), 128'(0));
    chk("rst_p_valid", 128'(core_p_valid), 128'(0));
    chk("rst_p_ready", 128'(mp_ready), 128'(0));
    do_reset();

    // Single core: core 2, id 7, response 0x1234
    new_req(2);
    req_id[2] = 5'd7;
    mq_ready  = 1'b1;
    #1;
    chk("single_q_ready", 128'(core_q_ready), 128'(4'b0100));
    chk("single_q_id", 128'(mq_id), 128'(7));
    tick();
    req_v[2] = 1'b0;
    mq_ready = 1'b0;
    #1;
    chk("single_out1", 128'(outstanding), 128'(1));
    mp_valid = 1'b1;
    mp_data  = 32'h1234;
    mp_id    = 5'd7;
    #1;
    chk("single_p_valid", 128'(core_p_valid), 128'(4'b0100));
    chk("single_p_id", 128'(core_p_id), 128'(7));
    chk("single_p_data", 128'(core_p_data), 128'(32'h1234));
    tick();
    mp_valid = 1'b0;
    #1;
    chk("single_out0", 128'(outstanding), 128'(0));
    tick();

    // Round robin: all cores requesting, unit always ready, responses drain every cycle
    do_reset();
    for (int i = 0; i < N; i++) new_req(i);
    mq_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      logic [N-1:0] exp_gnt;
      exp_gnt  = '0;
      exp_gnt[c % N] = 1'b1;
      mp_valid = (order_q.size() > 0);
      mp_data  = $urandom();
      #1;
      chk("rr_grant", 128'(core_q_ready), 128'(exp_gnt));
      tick();
      if (last_w >= 0) new_req(last_w);
    end
    set_idle();
    drain();

    // Stall lock: core 1 held while core 0 appears, then search resumes from 2
    do_reset();
    new_req(1);
    p1_payload = req_d[1];
    for (int s = 0; s < 3; s++) begin
      #1;
      chk("stall_q_data", 128'(mq_data), 128'(p1_payload));
      chk("stall_q_ready", 128'(core_q_ready), 128'(0));
      tick();
      if (s == 0) new_req(0);
    end
    mq_ready = 1'b1;
    #1;
    chk("stall_hs", 128'(core_q_ready), 128'(4'b0010));
    tick();
    req_v[1] = 1'b0;
    new_req(2);
    new_req(3);
    for (int g = 0; g < 3; g++) begin
      logic [N-1:0] exp_gnt;
      exp_gnt = '0;
      exp_gnt[(g + 2) % N] = 1'b1;
      #1;
      chk("stall_after", 128'(core_q_ready), 128'(exp_gnt));
      tick();
      if (last_w >= 0) req_v[last_w] = 1'b0;
    end

    // Full: four outstanding, a pop in the same cycle does not unblock issue
    new_req(1);
    #1;
    chk("full_q_ready", 128'(core_q_ready), 128'(0));
    chk("full_q_valid", 128'(mq_valid), 128'(0));
    chk("full_out", 128'(outstanding), 128'(4));
    tick();
    mp_valid = 1'b1;
    #1;
    chk("full_pop_blocked", 128'(core_q_ready), 128'(0));
    tick();
    mp_valid = 1'b0;
    #1;
    chk("full_after_pop", 128'(core_q_ready), 128'(4'b0010));
    chk("full_out3", 128'(outstanding), 128'(3));
    tick();
    req_v[1] = 1'b0;
    drain();

    // Ordering 3,0,3 with core 0 backpressure
    do_reset();
    mq_ready = 1'b1;
    new_req(3); tick(); req_v[3] = 1'b0;
    new_req(0); tick(); req_v[0] = 1'b0;
    new_req(3); tick(); req_v[3] = 1'b0;
    mq_ready = 1'b0;
    mp_valid = 1'b1;
    #1;
    chk("ord_first", 128'(core_p_valid), 128'(4'b1000));
    tick();
    core_p_ready[0] = 1'b0;
    for (int s = 0; s < 2; s++) begin
      #1;
      chk("ord_bp_valid", 128'(core_p_valid), 128'(4'b0001));
      chk("ord_bp_ready", 128'(mp_ready), 128'(0));
      tick();
    end
    core_p_ready[0] = 1'b1;
    #1;
    chk("ord_accept", 128'(mp_ready), 128'(1));
    tick();
    #1;
    chk("ord_last", 128'(core_p_valid), 128'(4'b1000));
    tick();
    mp_valid = 1'b0;
    tick();

    // Reset mid-operation with three outstanding
    do_reset();
    mq_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      new_req(c); tick(); req_v[c] = 1'b0;
    end
    mq_ready = 1'b0;
    #1;
    chk("mid_out3", 128'(outstanding), 128'(3));
    rst = 1'b1;
    model_clear();
    #1;
    chk("mid_rst_out", 128'(outstanding), 128'(0));
    tick();
    rst = 1'b0;
    #1;
    chk("mid_p_valid", 128'(core_p_valid), 128'(0));
    chk("mid_q_valid", 128'(mq_valid), 128'(0));
    new_req(1);
    new_req(3);
    mq_ready = 1'b1;
    #1;
    chk("mid_ptr0", 128'(core_q_ready), 128'(4'b0010));
    tick();
    req_v[1] = 1'b0;
    tick();
    req_v[3] = 1'b0;
    drain();

    // Randomized traffic
    do_reset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      for (int i = 0; i < N; i++) begin
        if (!req_v[i] && ($urandom_range(0, 1) == 0)) new_req(i);
        core_p_ready[i] = ($urandom_range(0, 3) != 0);
      end
      mq_ready = ($urandom_range(0, 3) != 0);
      mp_valid = (order_q.size() > 0) && ($urandom_range(0, 1) == 0);
      mp_data  = $urandom();
      mp_id    = IW'($urandom());
      tick();
      if (last_w >= 0) req_v[last_w] = 1'b0;
    end
    set_idle();
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
